// File: rtl/ps2_matrix_kbd.sv
// PS/2 set-2 keyboard receiver and make/break decoder driving the 40-bit Cobra1 key matrix.
// Bit index is row*5+col; a set bit means the key is currently held.
module ps2_matrix_kbd #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [39:0] kb_state,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  function automatic logic [6:0] key_map(input logic [7:0] code);
    logic [6:0] r;
    r = 7'd0;
    case (code)
      8'h12: r = {1'b1, 6'd0};   8'h1A: r = {1'b1, 6'd1};   8'h22: r = {1'b1, 6'd2};
      8'h21: r = {1'b1, 6'd3};   8'h2A: r = {1'b1, 6'd4};
      8'h1C: r = {1'b1, 6'd5};   8'h1B: r = {1'b1, 6'd6};   8'h23: r = {1'b1, 6'd7};
      8'h2B: r = {1'b1, 6'd8};   8'h34: r = {1'b1, 6'd9};
      8'h15: r = {1'b1, 6'd10};  8'h1D: r = {1'b1, 6'd11};  8'h24: r = {1'b1, 6'd12};
      8'h2D: r = {1'b1, 6'd13};  8'h2C: r = {1'b1, 6'd14};
      8'h16: r = {1'b1, 6'd15};  8'h1E: r = {1'b1, 6'd16};  8'h26: r = {1'b1, 6'd17};
      8'h25: r = {1'b1, 6'd18};  8'h2E: r = {1'b1, 6'd19};
      8'h45: r = {1'b1, 6'd20};  8'h46: r = {1'b1, 6'd21};  8'h3E: r = {1'b1, 6'd22};
      8'h3D: r = {1'b1, 6'd23};  8'h36: r = {1'b1, 6'd24};
      8'h4D: r = {1'b1, 6'd25};  8'h44: r = {1'b1, 6'd26};  8'h43: r = {1'b1, 6'd27};
      8'h3C: r = {1'b1, 6'd28};  8'h35: r = {1'b1, 6'd29};
      8'h5A: r = {1'b1, 6'd30};  8'h4B: r = {1'b1, 6'd31};  8'h42: r = {1'b1, 6'd32};
      8'h3B: r = {1'b1, 6'd33};  8'h33: r = {1'b1, 6'd34};
      8'h29: r = {1'b1, 6'd35};  8'h59: r = {1'b1, 6'd36};  8'h3A: r = {1'b1, 6'd37};
      8'h31: r = {1'b1, 6'd38};  8'h32: r = {1'b1, 6'd39};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  // Stage p0/p1: two-FF synchronisers; p2: delayed copy and registered falling edge
  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_dat_p0, ps2_dat_p1, ps2_dat_p2;
  logic fall_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      fall_p2    <= 1'b0;
    end else begin
      ps2_clk_p0 <= ps2_clk;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      fall_p2    <= ps2_clk_p2 & ~ps2_clk_p1;
    end
  end

  always_ff @(posedge clk) begin
    ps2_dat_p0 <= ps2_data;
    ps2_dat_p1 <= ps2_dat_p0;
    ps2_dat_p2 <= ps2_dat_p1;
  end

  // Receiver: frame_w is the shift register as it will look after this edge
  logic [3:0]      bit_cnt;
  logic [10:0]     shift_r;
  logic [TO_W-1:0] to_cnt;
  logic [10:0]     frame_w;
  logic            frame_ok;

  assign frame_w  = {ps2_dat_p2, shift_r[10:1]};
  assign frame_ok = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);

  always_ff @(posedge clk) begin
    if (fall_p2) shift_r <= frame_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 4'd0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= 8'h00;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_p2) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= frame_w[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          to_cnt    <= '0;
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // Decoder: consumes registered byte_valid/byte_data, kb_state lands one cycle later
  state_t      state, state_nxt;
  logic [39:0] kb_nxt;
  logic        key_hit;
  logic [5:0]  key_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      kb_state <= 40'd0;
    end else begin
      state    <= state_nxt;
      kb_state <= kb_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    kb_nxt             = kb_state;
    {key_hit, key_idx} = key_map(byte_data);
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == 8'hF0)      state_nxt = BRK;
          else if (byte_data == 8'hE0) state_nxt = EXT;
          else if (byte_data == 8'hAA) kb_nxt = 40'd0;
          else if (key_hit)            kb_nxt[key_idx] = 1'b1;
        end
        BRK: begin
          if (key_hit) kb_nxt[key_idx] = 1'b0;
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (byte_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Directed bench for ps2_matrix_kbd: drives PS/2 frames bit by bit and checks matrix, pulses and byte output.
module tb_ps2_matrix_kbd;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [39:0] kb_state;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int exp_bv = 0;
  int exp_fe = 0;

  ps2_matrix_kbd #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .kb_state   (kb_state),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (byte_valid === 1'b1) bv_cnt <= bv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (byte_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d);
    send_bits(d, 1'b0, 11);
    exp_bv++;
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_kb", kb_state, 40'd0);
    check("rst_bd", {32'd0, byte_data}, 40'h00);
    check("rst_bv", {39'd0, byte_valid}, 40'd0);
    check("rst_fe", {39'd0, frame_err}, 40'd0);

    frame(8'h1C);
    check("press_a", kb_state, 40'd1 << 5);
    check("press_a_bd", {32'd0, byte_data}, 40'h1C);
    frame(8'hF0);
    frame(8'h1C);
    check("release_a", kb_state, 40'd0);
    check("release_a_bv", 40'(bv_cnt), 40'd3);
    check("release_a_fe", 40'(fe_cnt), 40'd0);

    frame(8'h12);
    frame(8'h1A);
    check("chord", kb_state, 40'h3);
    for (int i = 0; i < 5; i++) frame(8'h1A);
    check("typematic", kb_state, 40'h3);
    frame(8'hF0);
    frame(8'h12);
    check("chord_rel_shift", kb_state, 40'h2);
    frame(8'hF0);
    frame(8'h1A);
    check("chord_rel_z", kb_state, 40'h0);

    frame(8'hE0);
    frame(8'h75);
    check("ext_make", kb_state, 40'd0);
    frame(8'hE0);
    frame(8'hF0);
    frame(8'h75);
    check("ext_break", kb_state, 40'd0);
    frame(8'h29);
    check("space_after_ext", kb_state, 40'd1 << 35);
    frame(8'hFA);
    check("unmapped_fa", kb_state, 40'd1 << 35);
    frame(8'hF0);
    frame(8'h29);
    check("space_rel", kb_state, 40'd0);
    check("bv_count_mid", 40'(bv_cnt), 40'(exp_bv));

    send_bits(8'h1C, 1'b1, 11);
    exp_fe++;
    check("badpar_fe", 40'(fe_cnt), 40'(exp_fe));
    check("badpar_bv", 40'(bv_cnt), 40'(exp_bv));
    check("badpar_kb", kb_state, 40'd0);
    check("badpar_bd", {32'd0, byte_data}, 40'h29);
    frame(8'h1C);
    check("after_badpar", kb_state, 40'd1 << 5);

    send_bits(8'h5A, 1'b0, 4);
    check("stall_pre_fe", 40'(fe_cnt), 40'(exp_fe));
    repeat (TO + 20) @(negedge clk);
    exp_fe++;
    check("timeout_fe", 40'(fe_cnt), 40'(exp_fe));
    frame(8'h5A);
    check("after_timeout", kb_state, (40'd1 << 30) | (40'd1 << 5));

    frame(8'hAA);
    check("bat_clear", kb_state, 40'd0);
    check("bat_bd", {32'd0, byte_data}, 40'hAA);

    frame(8'h1C);
    send_bits(8'h33, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_kb", kb_state, 40'd0);
    check("midrst_bd", {32'd0, byte_data}, 40'h00);
    check("midrst_pulses", {38'd0, byte_valid, frame_err}, 40'd0);
    frame(8'h3A);
    check("post_rst_kb", kb_state, 40'd1 << 37);
    check("post_rst_bd", {32'd0, byte_data}, 40'h3A);
    check("final_bv", 40'(bv_cnt), 40'(exp_bv));
    check("final_fe", 40'(fe_cnt), 40'(exp_fe));
    check("never_both", 40'(both_cnt), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
